// File: rtl/mem_bus_bridge.sv
// Load/store bridge from the MEM stage to a handshaked, variable-latency data bus.
// Holds the pipeline until one bus transaction completes and formats load data.
module mem_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  input  logic        cpu_req_write,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  input  logic [2:0]  cpu_req_funct3,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(TIMEOUT);
  localparam logic [CW:0] ONE   = (CW + 1)'(1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    off_q;
  logic [2:0]    funct3_q;
  logic          fault_q;

  logic          legal;
  logic          misaligned;
  logic          idle_fault;
  logic          req_ok;
  logic [3:0]    strb;
  logic [31:0]   lane_data;

  // Decode the held request: legality, alignment, and write lane placement.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    strb       = 4'b0000;
    lane_data  = cpu_req_wdata;
    case (cpu_req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~cpu_req_write;
      default:                legal = 1'b0;
    endcase
    case (cpu_req_funct3[1:0])
      2'b00: begin
        strb      = 4'b0001 << cpu_req_addr[1:0];
        lane_data = {4{cpu_req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = cpu_req_addr[0];
        strb       = cpu_req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{cpu_req_wdata[15:0]}};
      end
      default: begin
        misaligned = |cpu_req_addr[1:0];
        strb       = 4'b1111;
      end
    endcase
    if (!cpu_req_write) strb = 4'b0000;
  end

  assign idle_fault = (state == IDLE) && cpu_req_valid && (!legal || misaligned);
  assign req_ok     = cpu_req_valid && legal && !misaligned;

  assign cpu_stall = cpu_req_valid && (state != DONE) && !idle_fault;
  assign cpu_done  = (state == DONE) || idle_fault;
  assign cpu_fault = fault_q || idle_fault;

  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  return {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  return {24'd0, shifted[7:0]};
      3'b101:  return {16'd0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

  // Transaction FSM; rdata and fault are only nonzero during the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      off_q         <= 2'b00;
      funct3_q      <= 3'b000;
      fault_q       <= 1'b0;
      cpu_rdata     <= 32'd0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= 32'd0;
      bus_wdata     <= 32'd0;
      bus_wstrb     <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok) begin
            bus_req_valid <= 1'b1;
            bus_we        <= cpu_req_write;
            bus_addr      <= {cpu_req_addr[31:2], 2'b00};
            bus_wdata     <= lane_data;
            bus_wstrb     <= strb;
            off_q         <= cpu_req_addr[1:0];
            funct3_q      <= cpu_req_funct3;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            wait_cnt      <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            fault_q   <= bus_rsp_err;
            cpu_rdata <= (bus_rsp_err || bus_we) ? 32'd0
                                                 : format_load(bus_rsp_rdata, off_q, funct3_q);
            state     <= DONE;
          end else if ((TIMEOUT != 0) && (({1'b0, wait_cnt} + ONE) == LIMIT)) begin
            fault_q   <= 1'b1;
            cpu_rdata <= 32'd0;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          fault_q   <= 1'b0;
          cpu_rdata <= 32'd0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: directed test-plan steps followed by randomized
// transactions, checked against an arithmetic model of the access rules.
module tb_mem_bus_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_write;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic [2:0]  cpu_req_funct3;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_fault;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;

  int vectors     = 0;
  int miscompares = 0;

  mem_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_funct3(cpu_req_funct3), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_fault(cpu_fault),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference model: access size in bytes is 2**funct3[1:0].
  function automatic bit modelFault(bit wr, logic [2:0] f3, logic [31:0] addr);
    int unsigned bytes;
    bit ok;
    ok    = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    bytes = 1 << f3[1:0];
    return !ok || ((addr % bytes) != 0);
  endfunction

  function automatic logic [3:0] modelStrobe(bit wr, logic [2:0] f3, logic [31:0] addr);
    int unsigned bytes;
    if (!wr) return 4'b0000;
    bytes = 1 << f3[1:0];
    return 4'(((1 << bytes) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] modelWdata(logic [2:0] f3, logic [31:0] wdata);
    case (f3[1:0])
      2'd0:    return (wdata & 32'hFF) * 32'h01010101;
      2'd1:    return (wdata & 32'hFFFF) * 32'h00010001;
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(logic [2:0] f3, logic [31:0] addr, logic [31:0] word);
    longint unsigned bits, v;
    bits = 64'd8 << f3[1:0];
    if (bits >= 32) return word;
    v = ({32'd0, word} >> (8 * (addr % 4))) & ((64'd1 << bits) - 1);
    if (!f3[2] && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  task automatic idleCycle();
    @(posedge clk); #2;
    cpu_req_valid = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    #2;
    checkOutput("idle_done", cpu_done, 1'b0);
    checkOutput("idle_busvalid", bus_req_valid, 1'b0);
    checkOutput("idle_stall", cpu_stall, 1'b0);
  endtask

  // One MEM-stage request; rspDelay >= TO means no response arrives in time.
  task automatic applyStimulus(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int readyDelay,
                               input int rspDelay, input logic [31:0] rspWord,
                               input bit rspErr);
    bit fault, timedOut;
    int stallCount, waitCycles;
    fault = modelFault(wr, f3, addr);
    @(posedge clk); #2;
    cpu_req_valid  = 1'b1;
    cpu_req_write  = wr;
    cpu_req_addr   = addr;
    cpu_req_wdata  = wdata;
    cpu_req_funct3 = f3;
    bus_req_ready  = 1'b0;
    bus_rsp_valid  = 1'b0;
    #2;
    if (fault) begin
      checkOutput("imm_done", cpu_done, 1'b1);
      checkOutput("imm_fault", cpu_fault, 1'b1);
      checkOutput("imm_stall", cpu_stall, 1'b0);
      checkOutput("imm_rdata", cpu_rdata, 32'd0);
      checkOutput("imm_busvalid", bus_req_valid, 1'b0);
      @(posedge clk); #2;
      cpu_req_valid = 1'b0;
      #2;
      checkOutput("imm_nobus", bus_req_valid, 1'b0);
      return;
    end
    checkOutput("idle_req_done", cpu_done, 1'b0);
    stallCount = int'(cpu_stall);
    for (int k = 0; k <= readyDelay; k++) begin
      @(posedge clk); #2;
      bus_req_ready = (k == readyDelay);
      bus_rsp_valid = (k != readyDelay) && ($urandom_range(0, 1) == 1);
      bus_rsp_rdata = $urandom;
      bus_rsp_err   = ($urandom_range(0, 1) == 1);
      #2;
      checkOutput("req_valid", bus_req_valid, 1'b1);
      checkOutput("req_addr", bus_addr, addr & 32'hFFFF_FFFC);
      checkOutput("req_we", bus_we, wr);
      checkOutput("req_wstrb", bus_wstrb, modelStrobe(wr, f3, addr));
      if (wr) checkOutput("req_wdata", bus_wdata, modelWdata(f3, wdata));
      checkOutput("req_done", cpu_done, 1'b0);
      stallCount += int'(cpu_stall);
    end
    timedOut   = (TO != 0) && (rspDelay >= int'(TO));
    waitCycles = timedOut ? int'(TO) : rspDelay + 1;
    for (int j = 0; j < waitCycles; j++) begin
      @(posedge clk); #2;
      bus_req_ready = 1'b0;
      bus_rsp_valid = !timedOut && (j == rspDelay);
      bus_rsp_rdata = (j == rspDelay) ? rspWord : $urandom;
      bus_rsp_err   = rspErr;
      #2;
      checkOutput("wait_busvalid", bus_req_valid, 1'b0);
      checkOutput("wait_done", cpu_done, 1'b0);
      stallCount += int'(cpu_stall);
    end
    @(posedge clk); #2;
    bus_rsp_valid = 1'b0;
    #2;
    checkOutput("stall_cycles", stallCount, 2 + readyDelay + waitCycles);
    checkOutput("done", cpu_done, 1'b1);
    checkOutput("done_stall", cpu_stall, 1'b0);
    checkOutput("done_fault", cpu_fault, timedOut || rspErr);
    if (timedOut || rspErr) checkOutput("done_rdata_fault", cpu_rdata, 32'd0);
    else if (!wr) checkOutput("done_rdata", cpu_rdata, modelLoad(f3, addr, rspWord));
  endtask

  initial begin
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;

    rst            = 1'b1;
    cpu_req_valid  = 1'b0;
    cpu_req_write  = 1'b0;
    cpu_req_addr   = 32'd0;
    cpu_req_wdata  = 32'd0;
    cpu_req_funct3 = 3'd0;
    bus_req_ready  = 1'b0;
    bus_rsp_valid  = 1'b0;
    bus_rsp_rdata  = 32'd0;
    bus_rsp_err    = 1'b0;

    // Reset state.
    @(posedge clk); #2;
    checkOutput("rst_busvalid", bus_req_valid, 1'b0);
    checkOutput("rst_we", bus_we, 1'b0);
    checkOutput("rst_wstrb", bus_wstrb, 4'b0000);
    checkOutput("rst_addr", bus_addr, 32'd0);
    checkOutput("rst_wdata", bus_wdata, 32'd0);
    checkOutput("rst_done", cpu_done, 1'b0);
    checkOutput("rst_fault", cpu_fault, 1'b0);
    checkOutput("rst_rdata", cpu_rdata, 32'd0);
    checkOutput("rst_stall0", cpu_stall, 1'b0);
    cpu_req_valid  = 1'b1;
    cpu_req_funct3 = 3'b010;
    #1;
    checkOutput("rst_stall1", cpu_stall, 1'b1);
    cpu_req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    $display("[TB] reset released");

    // LW on a zero-latency bus.
    applyStimulus(1'b0, 3'b010, 32'h100, 32'd0, 0, 0, 32'hDEADBEEF, 1'b0);

    // Byte/half formatting, issued back to back.
    applyStimulus(1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 32'h80FF7F01, 1'b0);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'd0, 0, 0, 32'h80FF7F01, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h102, 32'd0, 0, 0, 32'h80FF7F01, 1'b0);
    applyStimulus(1'b0, 3'b101, 32'h100, 32'd0, 0, 0, 32'h80FF7F01, 1'b0);
    idleCycle();
    idleCycle();

    // Store lanes.
    applyStimulus(1'b1, 3'b000, 32'h201, 32'h000000AB, 1, 1, 32'd0, 1'b0);
    applyStimulus(1'b1, 3'b001, 32'h202, 32'h00001234, 0, 2, 32'd0, 1'b0);

    // Misaligned and illegal requests.
    applyStimulus(1'b0, 3'b010, 32'h102, 32'd0, 0, 0, 32'd0, 1'b0);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'd0, 0, 0, 32'd0, 1'b0);

    // Backpressure followed by an error response.
    applyStimulus(1'b0, 3'b010, 32'h400, 32'd0, 5, 1, 32'h12345678, 1'b1);

    // Timeout with no response.
    applyStimulus(1'b0, 3'b010, 32'h500, 32'd0, 0, 10, 32'd0, 1'b0);
    idleCycle();

    // Reset pulsed while in REQ, then a stale response.
    @(posedge clk); #2;
    cpu_req_valid  = 1'b1;
    cpu_req_write  = 1'b0;
    cpu_req_addr   = 32'h300;
    cpu_req_funct3 = 3'b010;
    @(posedge clk); #2;
    bus_req_ready = 1'b0;
    #2;
    checkOutput("rstmid_req", bus_req_valid, 1'b1);
    #1;
    rst           = 1'b1;
    cpu_req_valid = 1'b0;
    #1;
    checkOutput("rstmid_busvalid", bus_req_valid, 1'b0);
    checkOutput("rstmid_done", cpu_done, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'hCAFEF00D;
    bus_rsp_err   = 1'b1;
    #2;
    checkOutput("stale_done", cpu_done, 1'b0);
    checkOutput("stale_fault", cpu_fault, 1'b0);
    idleCycle();
    checkOutput("stale_rdata", cpu_rdata, 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h600, 32'd0, 0, 0, 32'h0BADBEEF, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      wr   = ($urandom_range(0, 1) == 1);
      f3   = 3'($urandom_range(0, 2));
      if (!wr && $urandom_range(0, 2) == 0) f3[2] = 1'b1;
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      applyStimulus(wr, f3, addr, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 5), $urandom, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) idleCycle();
    end
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
